// File: rtl/k005297_rot20_timerctl.sv
// Ring/sequencer front end for the 2556-step serial timer: 20-phase ring, count enable, latch strobe, IRQ.
// Build option: K005297_TIMERCTL_PERIODIC_LATCH_EN also strobes the output latch at step 14 of every RUN frame.
//
// state    | meaning
// ST_IDLE  | counting off (CNT=0), waiting for a start request
// ST_CLR   | one full frame with CNT=0 so every timer bit shifts to zero
// ST_RUN   | counting (CNT=1), watching for time-over
module k005297_rot20_timerctl #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic        i_MCLK,
  input  logic        i_RST,
  input  logic        i_CLK2M_PCEN_n,
  input  logic        i_TIMER_START,
  input  logic        i_TIMER_STOP,
  input  logic        i_LATCH_REQ,
  input  logic        i_IRQ_ACK,
  input  logic        i_TIMER25K_TIMEOVER_n,
  output logic [19:0] o_ROT20_n,
  output logic        o_TIMER25K_CNT,
  output logic        o_TIMER25K_OUTLATCH_LD_n,
  output logic        o_TIMEOVER_IRQ,
  output logic        o_LATCH_VALID,
  output logic        o_BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLR  = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic cen;
  logic at_13, at_14, at_19;
  logic frame_end;
  logic tov_hit;
  logic start_pend, stop_pend, latch_pend;
  logic tov_flag;
  logic ld_active;
  logic ld_serve;

  assign cen       = ~i_CLK2M_PCEN_n;
  assign at_13     = ~o_ROT20_n[13];
  assign at_14     = ~o_ROT20_n[14];
  assign at_19     = ~o_ROT20_n[19];
  assign frame_end = cen & at_19;
  // Time-over is only meaningful while the ring sits at step 13.
  assign tov_hit   = cen & at_13 & (state == ST_RUN) & ~i_TIMER25K_TIMEOVER_n;

`ifdef K005297_TIMERCTL_PERIODIC_LATCH_EN
  assign ld_serve = latch_pend | (state == ST_RUN);
`else
  assign ld_serve = latch_pend;
`endif

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      o_ROT20_n <= 20'hFFFFE;
    end else if (cen) begin
      o_ROT20_n <= {o_ROT20_n[18:0], o_ROT20_n[19]};
    end
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      start_pend <= 1'b0;
      stop_pend  <= 1'b0;
      latch_pend <= 1'b0;
    end else begin
      start_pend <= (start_pend & ~frame_end) | i_TIMER_START;
      stop_pend  <= (stop_pend  & ~frame_end) | i_TIMER_STOP;
      latch_pend <= (latch_pend & ~(cen & at_13)) | i_LATCH_REQ;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start_pend) state_nxt = ST_CLR;
      end
      ST_CLR: begin
        if (start_pend)     state_nxt = ST_CLR;
        else if (stop_pend) state_nxt = ST_IDLE;
        else                state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (start_pend)     state_nxt = ST_CLR;
        else if (stop_pend) state_nxt = ST_IDLE;
        else if (tov_flag)  state_nxt = AUTO_RELOAD ? ST_CLR : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      state <= ST_IDLE;
    end else if (frame_end) begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      tov_flag       <= 1'b0;
      o_TIMEOVER_IRQ <= 1'b0;
    end else begin
      if (frame_end)    tov_flag <= 1'b0;
      else if (tov_hit) tov_flag <= 1'b1;

      if (tov_hit)        o_TIMEOVER_IRQ <= 1'b1;
      else if (i_IRQ_ACK) o_TIMEOVER_IRQ <= 1'b0;
    end
  end

  // The strobe decision is frozen on entry to step 14, so a request landing
  // inside step 14 stays pending for the next frame.
  always_ff @(posedge i_MCLK or posedge i_RST) begin
    if (i_RST) begin
      ld_active     <= 1'b0;
      o_LATCH_VALID <= 1'b0;
    end else begin
      if (cen & at_13)      ld_active <= ld_serve;
      else if (cen & at_14) ld_active <= 1'b0;

      if (i_LATCH_REQ)
        o_LATCH_VALID <= 1'b0;
      else if (cen & at_14 & ld_active & ~latch_pend)
        o_LATCH_VALID <= 1'b1;
    end
  end

  assign o_TIMER25K_OUTLATCH_LD_n = ~ld_active;
  assign o_TIMER25K_CNT           = (state == ST_RUN);
  assign o_BUSY                   = (state != ST_IDLE);

endmodule
